// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and helpers for the packet-bus round-robin scheduler.
// The header destination ID sits in the top ID_W bits of every packet.
package bus_sched_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // Packets of any width up to PKT_MAX_W are passed zero-extended.
  function automatic logic [ID_W-1:0] hdr_id(input logic [PKT_MAX_W-1:0] pkt, input int width);
    return ID_W'(pkt >> (width - ID_W));
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Handshake bundle between the per-driver FIFO agents and the bus scheduler.
// The master modport is the scheduler side; the slave modport is the FIFO/data-path side.
interface bus_rr_scheduler_if #(
  parameter int pckg_sz = 16,
  parameter int drvrs   = 16,
  parameter int drop_w  = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [7:0]               gnt_id;
  logic                     busy;
  logic [drop_w-1:0]        drop_cnt;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, gnt_id, busy, drop_cnt
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, gnt_id, busy, drop_cnt
  );
endinterface

// File: rtl/bus_rr_scheduler_pick.sv
// Combinational rotating-priority picker: first request found scanning
// upward from last+1, wrapping modulo drvrs.
module bus_rr_pick #(
  parameter int drvrs = 16
) (
  input  logic [drvrs-1:0] req,
  input  logic [7:0]       last,
  output logic [7:0]       gnt_idx,
  output logic             any
);

  localparam int IW = $clog2(drvrs);

  logic [7:0]       cand_idx [drvrs];
  logic [drvrs-1:0] hit;

  // Slot gi holds the driver that is (gi+1) positions after the last grant.
  for (genvar gi = 0; gi < drvrs; gi++) begin : g_cand
    logic [8:0] sum;
    assign sum          = {1'b0, last} + 9'(gi + 1);
    assign cand_idx[gi] = (sum >= 9'(drvrs)) ? 8'(sum - 9'(drvrs)) : sum[7:0];
    assign hit[gi]      = req[cand_idx[gi][IW-1:0]];
  end

  always_comb begin
    gnt_idx = '0;
    for (int k = drvrs - 1; k >= 0; k--) begin
      if (hit[k]) gnt_idx = cand_idx[k];
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Single-bus round-robin scheduler: grants one pending driver, pops its FIFO
// head, and pushes the packet to its destination or to all other drivers.
module bus_rr_scheduler #(
  parameter int pckg_sz   = 16,
  parameter int drvrs     = 16,
  parameter int broadcast = 255,
  parameter int drop_w    = 16
) (
  input logic          clk,
  input logic          reset,
  bus_rr_scheduler_if.master bus
);
  import bus_sched_pkg::*;

  localparam int IW = $clog2(drvrs);
  localparam logic [drvrs-1:0] ONE_HOT0 = {{(drvrs-1){1'b0}}, 1'b1};

  state_t              state_reg, state_next;
  logic [7:0]          gnt_reg, gnt_next;
  logic [7:0]          last_reg, last_next;
  logic [pckg_sz-1:0]  data_reg, data_next;
  logic [drvrs-1:0]    pop_reg, pop_next;
  logic [drvrs-1:0]    push_reg, push_next;
  logic [pckg_sz-1:0]  dpush_reg, dpush_next;
  logic                busy_reg, busy_next;
  logic [drop_w-1:0]   drop_reg, drop_next;

  logic [7:0]          pick_idx;
  logic                pick_any;
  logic [7:0]          dest;
  logic [pckg_sz-1:0]  words [drvrs];

  for (genvar gi = 0; gi < drvrs; gi++) begin : g_words
    assign words[gi] = bus.D_pop[gi*pckg_sz +: pckg_sz];
  end

  bus_rr_pick #(.drvrs(drvrs)) u_pick (
    .req     (bus.pndng),
    .last    (last_reg),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      last_reg  <= 8'(drvrs - 1);
      data_reg  <= '0;
      pop_reg   <= '0;
      push_reg  <= '0;
      dpush_reg <= '0;
      busy_reg  <= 1'b0;
      drop_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
      data_reg  <= data_next;
      pop_reg   <= pop_next;
      push_reg  <= push_next;
      dpush_reg <= dpush_next;
      busy_reg  <= busy_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    data_next  = data_reg;
    pop_next   = '0;
    push_next  = '0;
    dpush_next = dpush_reg;
    drop_next  = drop_reg;
    dest       = hdr_id(PKT_MAX_W'(data_reg), pckg_sz);
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          gnt_next   = pick_idx;
          state_next = POP;
        end
      end
      POP: begin
        // A request withdrawn after the grant is dropped without touching last_gnt.
        if (bus.pndng[gnt_reg[IW-1:0]]) begin
          pop_next   = ONE_HOT0 << gnt_reg;
          data_next  = words[gnt_reg[IW-1:0]];
          state_next = PUSH;
        end else begin
          state_next = IDLE;
        end
      end
      PUSH: begin
        if (dest == 8'(broadcast)) begin
          push_next = ~(ONE_HOT0 << gnt_reg);
        end else if (dest < 8'(drvrs)) begin
          push_next = ONE_HOT0 << dest;
        end else if (drop_reg != '1) begin
          drop_next = drop_reg + 1'b1;
        end
        dpush_next = data_reg;
        last_next  = gnt_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign bus.pop      = pop_reg;
  assign bus.push     = push_reg;
  assign bus.D_push   = dpush_reg;
  assign bus.gnt_id   = gnt_reg;
  assign bus.busy     = busy_reg;
  assign bus.drop_cnt = drop_reg;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: table of single-packet transactions
// plus hand sequences for fairness, withdrawn requests and mid-packet reset.
module tb_bus_rr_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_rr_scheduler_if #(.pckg_sz(16), .drvrs(16), .drop_w(16)) bus ();

  bus_rr_scheduler #(.pckg_sz(16), .drvrs(16), .broadcast(255), .drop_w(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] word;
    logic [15:0] exp_pop;
    logic [15:0] exp_push;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.pndng = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int npop;
    int last_c;
    int pidx;

    vecs[0] = '{3,  16'h05AB, 16'h0008, 16'h0020, 16'd0};
    vecs[1] = '{2,  16'hFF11, 16'h0004, 16'hFFFB, 16'd0};
    vecs[2] = '{0,  16'h2233, 16'h0001, 16'h0000, 16'd1};
    vecs[3] = '{7,  16'h0712, 16'h0080, 16'h0080, 16'd1};
    vecs[4] = '{15, 16'h00AA, 16'h8000, 16'h0001, 16'd1};
    vecs[5] = '{9,  16'h10CC, 16'h0200, 16'h0000, 16'd2};
    vecs[6] = '{15, 16'hFFEE, 16'h8000, 16'h7FFF, 16'd2};
    vecs[7] = '{1,  16'h0F55, 16'h0002, 16'h8000, 16'd2};

    bus.pndng = '0;
    bus.D_pop = '0;
    do_reset();
    chk("rst_pop", 32'(bus.pop), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_dpush", 32'(bus.D_push), 0);
    chk("rst_gnt", 32'(bus.gnt_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_drop", 32'(bus.drop_cnt), 0);

    for (int v = 0; v < 8; v++) begin
      bus.D_pop[vecs[v].idx*16 +: 16] = vecs[v].word;
      bus.pndng = 16'(1) << vecs[v].idx;
      step();
      chk("vec_gnt", 32'(bus.gnt_id), 32'(vecs[v].idx));
      chk("vec_busy_on", 32'(bus.busy), 1);
      chk("vec_no_early_pop", 32'(bus.pop), 0);
      step();
      chk("vec_pop", 32'(bus.pop), 32'(vecs[v].exp_pop));
      chk("vec_no_early_push", 32'(bus.push), 0);
      bus.pndng = '0;
      step();
      chk("vec_push", 32'(bus.push), 32'(vecs[v].exp_push));
      chk("vec_dpush", 32'(bus.D_push), 32'(vecs[v].word));
      chk("vec_drop", 32'(bus.drop_cnt), 32'(vecs[v].exp_drop));
      chk("vec_pop_clear", 32'(bus.pop), 0);
      step();
      chk("vec_busy_off", 32'(bus.busy), 0);
      chk("vec_push_clear", 32'(bus.push), 0);
      chk("vec_dpush_hold", 32'(bus.D_push), 32'(vecs[v].word));
      $display("vec %0d: drv=%0d word=%h pop=%h push=%h drop=%0d", v, vecs[v].idx,
               vecs[v].word, vecs[v].exp_pop, vecs[v].exp_push, vecs[v].exp_drop);
    end

    // Reset during the PUSH cycle of a packet from driver 4.
    bus.D_pop[4*16 +: 16] = 16'h0177;
    bus.pndng = 16'h0010;
    step();
    chk("mid_gnt", 32'(bus.gnt_id), 4);
    step();
    chk("mid_pop", 32'(bus.pop), 32'h0010);
    reset = 1'b1;
    bus.pndng = '0;
    step();
    chk("mid_push", 32'(bus.push), 0);
    chk("mid_pop_rst", 32'(bus.pop), 0);
    chk("mid_gnt_rst", 32'(bus.gnt_id), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_drop", 32'(bus.drop_cnt), 0);
    chk("mid_dpush", 32'(bus.D_push), 0);
    reset = 1'b0;
    bus.pndng = 16'h0011;
    step();
    chk("mid_next_gnt", 32'(bus.gnt_id), 0);
    chk("mid_next_busy", 32'(bus.busy), 1);
    $display("reset mid-packet: next grant=%0d", bus.gnt_id);

    // Fairness with every driver pending.
    do_reset();
    for (int i = 0; i < 16; i++) bus.D_pop[i*16 +: 16] = {8'((i + 1) % 16), 8'(i)};
    bus.pndng = 16'hFFFF;
    npop = 0;
    last_c = -1;
    for (int c = 1; c <= 48; c++) begin
      step();
      chk("fair_excl", 32'((bus.pop != 0) && (bus.push != 0)), 0);
      if (bus.pop != 0) begin
        pidx = -1;
        for (int b = 0; b < 16; b++) if (bus.pop[b]) pidx = b;
        chk("fair_onehot", 32'($countones(bus.pop)), 1);
        chk("fair_order", 32'(pidx), 32'(npop));
        if (last_c < 0) chk("fair_first_cycle", 32'(c), 2);
        else chk("fair_gap", 32'(c - last_c), 3);
        last_c = c;
        npop++;
      end
    end
    chk("fair_count", 32'(npop), 16);
    $display("fairness: %0d pops in 48 cycles", npop);

    // Request withdrawn after the grant.
    do_reset();
    bus.D_pop[5*16 +: 16] = 16'h0133;
    bus.pndng = 16'h0020;
    step();
    chk("wd_gnt", 32'(bus.gnt_id), 5);
    bus.pndng = '0;
    step();
    chk("wd_no_pop", 32'(bus.pop), 0);
    chk("wd_idle", 32'(bus.busy), 0);
    step();
    chk("wd_no_push", 32'(bus.push), 0);
    bus.pndng = 16'h0020;
    step();
    chk("wd_regnt", 32'(bus.gnt_id), 5);
    step();
    chk("wd_pop", 32'(bus.pop), 32'h0020);
    bus.pndng = '0;
    step();
    chk("wd_push", 32'(bus.push), 32'h0002);
    chk("wd_dpush", 32'(bus.D_push), 32'h0133);
    $display("withdrawn request: regrant=5 push=%h", bus.push);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
